// File: rtl/bubble_host_receiver.sv
// Host-side bubble page reader: drives shift/replicator/bootloop enables and captures returned bit pairs.
// Optional CRC-16/CCITT over the captured stream when BUBBLE_RX_CRC_EN is defined.
module bubble_host_receiver #(
    parameter int BIT_PERIOD   = 48,
    parameter int SETUP_BITS   = 4,
    parameter int REP_BITS     = 2,
    parameter int LATENCY_BITS = 16,
    parameter int PAGE_PAIRS   = 512
) (
    input  logic        master_clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        boot_mode,
    input  logic        abort,
    input  logic        bubble_out_odd,
    input  logic        bubble_out_even,
    output logic        bubble_shift_enable,
    output logic        replicator_enable,
    output logic        bootloop_enable,
    output logic [10:0] buffer_write_address,
    output logic [1:0]  buffer_write_data,
    output logic        buffer_write_enable,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_crc
);

    localparam int BW = $clog2(BIT_PERIOD + 1);
    localparam int SMAX = (SETUP_BITS > REP_BITS)
                        ? ((SETUP_BITS > LATENCY_BITS) ? SETUP_BITS : LATENCY_BITS)
                        : ((REP_BITS > LATENCY_BITS) ? REP_BITS : LATENCY_BITS);
    localparam int SW = $clog2(SMAX + 1);

    localparam logic [BW-1:0] BIT_LAST   = BW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] BIT_MID    = BW'(BIT_PERIOD / 2);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_BITS - 1);
    localparam logic [SW-1:0] REP_LAST   = SW'(REP_BITS - 1);
    localparam logic [SW-1:0] LAT_LAST   = SW'(LATENCY_BITS - 1);
    localparam logic [10:0]   PAIR_LAST  = 11'(PAGE_PAIRS - 1);

    if (PAGE_PAIRS > 2048) begin : g_bad_page
        $error("PAGE_PAIRS must not exceed 2048");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REP,
        S_LAT,
        S_CAP,
        S_FIN
    } state_t;

    state_t state, state_nxt;

    logic          odd_s1, odd_s2, even_s1, even_s2;
    logic [BW-1:0] bit_cnt;
    logic [SW-1:0] slot_cnt;
    logic [10:0]   pair_idx;
    logic [10:0]   addr_q;
    logic [1:0]    data_q;
    logic          we_q;
    logic          boot_q;
    logic          slot_tick;
    logic          enter_setup;
    logic          sample;
    logic          wr_fire;

    assign slot_tick   = (state != S_IDLE) && (bit_cnt == BIT_LAST);
    assign enter_setup = (state == S_IDLE) && (state_nxt == S_SETUP);
    assign sample      = (state == S_CAP) && (bit_cnt == BIT_MID) && !abort;
    assign wr_fire     = we_q && !abort;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_SETUP;
            S_SETUP: if (slot_tick && slot_cnt == SETUP_LAST) state_nxt = S_REP;
            S_REP:   if (slot_tick && slot_cnt == REP_LAST) state_nxt = S_LAT;
            S_LAT:   if (slot_tick && slot_cnt == LAT_LAST) state_nxt = S_CAP;
            S_CAP:   if (wr_fire && pair_idx == PAIR_LAST) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            odd_s1  <= 1'b0;
            odd_s2  <= 1'b0;
            even_s1 <= 1'b0;
            even_s2 <= 1'b0;
            boot_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            odd_s1  <= bubble_out_odd;
            odd_s2  <= odd_s1;
            even_s1 <= bubble_out_even;
            even_s2 <= even_s1;
            if (enter_setup) boot_q <= boot_mode;
        end
    end

    // Slot counter restarts on every state change so each phase counts its own ticks.
    always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= '0;
            slot_cnt <= '0;
        end else begin
            if (enter_setup) begin
                bit_cnt <= '0;
            end else if (state != S_IDLE) begin
                bit_cnt <= slot_tick ? '0 : bit_cnt + 1'b1;
            end
            if (state_nxt != state) begin
                slot_cnt <= '0;
            end else if (slot_tick) begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
            we_q     <= 1'b0;
            data_q   <= 2'b00;
            addr_q   <= '0;
            pair_idx <= '0;
        end else begin
            we_q <= sample;
            if (sample) data_q <= {even_s2, odd_s2};
            if (enter_setup) begin
                addr_q   <= '0;
                pair_idx <= '0;
            end else begin
                if (sample) addr_q <= pair_idx;
                if (wr_fire && pair_idx != PAIR_LAST) pair_idx <= pair_idx + 1'b1;
            end
        end
    end

    assign bubble_shift_enable  = (state == S_SETUP) || (state == S_REP)
                               || (state == S_LAT) || (state == S_CAP);
    assign replicator_enable    = (state == S_REP) && !boot_q;
    assign bootloop_enable      = (state == S_REP) && boot_q;
    assign busy                 = (state != S_IDLE);
    assign done                 = (state == S_FIN);
    assign buffer_write_enable  = wr_fire;
    assign buffer_write_data    = data_q;
    assign buffer_write_address = addr_q;

`ifdef BUBBLE_RX_CRC_EN
    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    logic [15:0] crc_q;

    // Odd bit enters the register ahead of even bit.
    always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 16'h0000;
        end else if (enter_setup) begin
            crc_q <= 16'hFFFF;
        end else if (wr_fire) begin
            crc_q <= crc_bit(crc_bit(crc_q, data_q[0]), data_q[1]);
        end
    end

    assign rx_crc = crc_q;
`else
    assign rx_crc = 16'h0000;
`endif

endmodule
